// File: rtl/dsp48a1_pkg.sv
// Shared widths, vector field layout and sequencer state encoding for the DSP48A1 self-test.
package dsp48a1_pkg;

  localparam int WIDTH_1 = 8;
  localparam int WIDTH_2 = 18;
  localparam int WIDTH_3 = 36;
  localparam int WIDTH_4 = 48;

  localparam int STIM_W = 177;
  localparam int EXP_W  = 103;

  // Stimulus word {A,B,C,D,BCIN,OPMODE,PCIN,CARRYIN}, LSB offsets
  localparam int STIM_CARRYIN_LSB = 0;
  localparam int STIM_PCIN_LSB    = 1;
  localparam int STIM_OPMODE_LSB  = 49;
  localparam int STIM_BCIN_LSB    = 57;
  localparam int STIM_D_LSB       = 75;
  localparam int STIM_C_LSB       = 93;
  localparam int STIM_B_LSB       = 141;
  localparam int STIM_A_LSB       = 159;

  // Expected word {BCOUT,M,CARRYOUT,P}, LSB offsets
  localparam int EXP_P_LSB        = 0;
  localparam int EXP_CARRYOUT_LSB = 48;
  localparam int EXP_M_LSB        = 49;
  localparam int EXP_BCOUT_LSB    = 85;

  typedef enum logic [2:0] {
    IDLE,
    RST_DSP,
    APPLY,
    WAIT,
    CHECK,
    DONE
  } seq_state_e;

endpackage

// File: rtl/dsp48a1_vec_mem.sv
// Stimulus/expected vector store: one write port, one registered read port with read enable.
module dsp48a1_vec_mem
  import dsp48a1_pkg::*;
#(
  parameter int unsigned NUM_VEC = 16,
  parameter int unsigned AW      = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [STIM_W-1:0] i_wr_stim,
  input  logic [EXP_W-1:0]  i_wr_exp,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [STIM_W-1:0] o_rd_stim,
  output logic [EXP_W-1:0]  o_rd_exp
);

  logic [STIM_W-1:0] r_stim_mem [NUM_VEC];
  logic [EXP_W-1:0]  r_exp_mem  [NUM_VEC];
  logic [STIM_W-1:0] r_rd_stim;
  logic [EXP_W-1:0]  r_rd_exp;

  // Array write; contents survive RST on purpose
  always_ff @(posedge CLK) begin
    if (i_wr_en) begin
      r_stim_mem[i_wr_addr] <= i_wr_stim;
      r_exp_mem[i_wr_addr]  <= i_wr_exp;
    end
  end

  // Read register doubles as the DSP-facing vector register, so it holds unless re-enabled
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_stim <= '0;
      r_rd_exp  <= '0;
    end else if (i_rd_en) begin
      r_rd_stim <= r_stim_mem[i_rd_addr];
      r_rd_exp  <= r_exp_mem[i_rd_addr];
    end
  end

  assign o_rd_stim = r_rd_stim;
  assign o_rd_exp  = r_rd_exp;

endmodule

// File: rtl/dsp48a1_vector_sequencer.sv
// Applies stored vectors to a DSP48A1, samples its results LATENCY edges later and tallies mismatches.
module dsp48a1_vector_sequencer
  import dsp48a1_pkg::*;
#(
  parameter int unsigned NUM_VEC = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned RST_CYC = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               vec_wr_en,
  input  logic [AW-1:0]      vec_wr_addr,
  input  logic [STIM_W-1:0]  vec_wr_stim,
  input  logic [EXP_W-1:0]   vec_wr_exp,
  input  logic [AW:0]        num_vec,
  input  logic               start,
  output logic [WIDTH_2-1:0] dsp_A,
  output logic [WIDTH_2-1:0] dsp_B,
  output logic [WIDTH_4-1:0] dsp_C,
  output logic [WIDTH_2-1:0] dsp_D,
  output logic [WIDTH_2-1:0] dsp_BCIN,
  output logic [WIDTH_1-1:0] dsp_OPMODE,
  output logic [WIDTH_4-1:0] dsp_PCIN,
  output logic               dsp_CARRYIN,
  output logic               dsp_ce,
  output logic               dsp_rst,
  input  logic [WIDTH_2-1:0] dsp_BCOUT,
  input  logic [WIDTH_3-1:0] dsp_M,
  input  logic               dsp_CARRYOUT,
  input  logic [WIDTH_4-1:0] dsp_P,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [AW:0]        err_cnt,
  output logic [AW-1:0]      first_err
);

  localparam int unsigned CNT_MAX   = (RST_CYC > LATENCY) ? RST_CYC : LATENCY;
  localparam int unsigned CW        = $clog2(CNT_MAX + 1);
  localparam int unsigned WAIT_LAST = (LATENCY >= 2) ? LATENCY - 2 : 0;
  localparam logic [AW:0] NV_MAX    = (AW+1)'(NUM_VEC);

  seq_state_e        r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [AW-1:0]     r_idx, w_idx_nxt;
  logic [AW-1:0]     r_last, w_last_nxt, w_last_in;
  logic [AW:0]       r_err_cnt, w_err_cnt_nxt;
  logic [AW-1:0]     r_first_err, w_first_err_nxt;
  logic [AW:0]       w_nv_m1;
  logic              w_wr_en, w_rd_en, w_mismatch;
  logic [AW-1:0]     w_rd_addr;
  logic [STIM_W-1:0] w_stim;
  logic [EXP_W-1:0]  w_exp;

  assign w_wr_en = vec_wr_en && (r_state == IDLE);

  dsp48a1_vec_mem #(
    .NUM_VEC (NUM_VEC),
    .AW      (AW)
  ) u_vec_mem (
    .CLK       (CLK),
    .RST       (RST),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (vec_wr_addr),
    .i_wr_stim (vec_wr_stim),
    .i_wr_exp  (vec_wr_exp),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_stim (w_stim),
    .o_rd_exp  (w_exp)
  );

  // Last index to run: 0 and out-of-range requests mean the whole memory
  always_comb begin
    w_nv_m1 = num_vec - (AW+1)'(1);
    if ((num_vec == '0) || (num_vec > NV_MAX)) begin
      w_last_in = AW'(NUM_VEC - 1);
    end else begin
      w_last_in = w_nv_m1[AW-1:0];
    end
  end

  // X/Z on any result must count as a mismatch, hence case equality
  assign w_mismatch = !((dsp_BCOUT === w_exp[EXP_BCOUT_LSB +: WIDTH_2]) &&
                        (dsp_M === w_exp[EXP_M_LSB +: WIDTH_3]) &&
                        (dsp_CARRYOUT === w_exp[EXP_CARRYOUT_LSB]) &&
                        (dsp_P === w_exp[EXP_P_LSB +: WIDTH_4]));

  // Next-state, counters, prefetch control and result bookkeeping
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_last_nxt      = r_last;
    w_err_cnt_nxt   = r_err_cnt;
    w_first_err_nxt = r_first_err;
    w_rd_en         = 1'b0;
    w_rd_addr       = r_idx;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt     = RST_DSP;
          w_cnt_nxt       = '0;
          w_idx_nxt       = '0;
          w_last_nxt      = w_last_in;
          w_err_cnt_nxt   = '0;
          w_first_err_nxt = '0;
        end
      end
      RST_DSP: begin
        if (r_cnt == CW'(RST_CYC - 1)) begin
          // Fetch vector 0 so it lands on the outputs as APPLY begins
          w_state_nxt = APPLY;
          w_rd_en     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      APPLY: begin
        w_cnt_nxt   = '0;
        w_state_nxt = (LATENCY == 1) ? CHECK : WAIT;
      end
      WAIT: begin
        if (r_cnt == CW'(WAIT_LAST)) begin
          w_state_nxt = CHECK;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      CHECK: begin
        if (w_mismatch) begin
          if (r_err_cnt == '0) w_first_err_nxt = r_idx;
          if (r_err_cnt != '1) w_err_cnt_nxt = r_err_cnt + (AW+1)'(1);
        end
        if (r_idx == r_last) begin
          w_state_nxt = DONE;
        end else begin
          w_idx_nxt   = r_idx + AW'(1);
          w_rd_addr   = r_idx + AW'(1);
          w_rd_en     = 1'b1;
          w_state_nxt = APPLY;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and status registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_last      <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_last      <= w_last_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_first_err <= w_first_err_nxt;
    end
  end

  assign dsp_A       = w_stim[STIM_A_LSB +: WIDTH_2];
  assign dsp_B       = w_stim[STIM_B_LSB +: WIDTH_2];
  assign dsp_C       = w_stim[STIM_C_LSB +: WIDTH_4];
  assign dsp_D       = w_stim[STIM_D_LSB +: WIDTH_2];
  assign dsp_BCIN    = w_stim[STIM_BCIN_LSB +: WIDTH_2];
  assign dsp_OPMODE  = w_stim[STIM_OPMODE_LSB +: WIDTH_1];
  assign dsp_PCIN    = w_stim[STIM_PCIN_LSB +: WIDTH_4];
  assign dsp_CARRYIN = w_stim[STIM_CARRYIN_LSB];

  assign dsp_rst   = (r_state == RST_DSP);
  assign dsp_ce    = (r_state == APPLY) || (r_state == WAIT) || (r_state == CHECK) ||
                     (r_state == DONE);
  assign busy      = (r_state == RST_DSP) || (r_state == APPLY) || (r_state == WAIT) ||
                     (r_state == CHECK);
  assign done      = (r_state == DONE);
  assign pass      = done && (r_err_cnt == '0);
  assign err_cnt   = r_err_cnt;
  assign first_err = r_first_err;

endmodule
